// File: rtl/rand_walk_pkg.sv
// Shared types and helpers for the random-walk position controller.
package rand_walk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SAMPLE  = 2'd1,
    ST_UPDATE  = 2'd2,
    ST_PUBLISH = 2'd3
  } rw_state_e;

  localparam int unsigned STEP_W = 4;
  localparam logic [STEP_W-1:0] STEP_NEG_LIMIT = 4'b1000;

  // -8 is folded to 0 so the walk stays symmetric around zero.
  function automatic logic signed [31:0] step_scale(input logic [STEP_W-1:0] raw,
                                                    input int unsigned shift);
    logic signed [31:0] ext;
    if (raw == STEP_NEG_LIMIT) ext = '0;
    else                       ext = {{(32-STEP_W){raw[STEP_W-1]}}, raw};
    return ext <<< shift;
  endfunction

endpackage

// File: rtl/rand_walk_tick.sv
// Step-tick prescaler: one-cycle tick every TICK_DIV enabled clocks.
module rand_walk_tick
  import rand_walk_pkg::*;
#(
  parameter int unsigned TICK_DIV = 833333
) (
  input  logic clock,
  input  logic reset_n,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] TC = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = enable && (cnt == TC);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= (cnt == TC) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/rand_walk_ctrl.sv
// Bounded random-walk position accumulator with valid/ready publish.
// Define RAND_WALK_REFLECT_EN to reflect off the bounds instead of saturating.
module rand_walk_ctrl
  import rand_walk_pkg::*;
#(
  parameter int unsigned POS_W      = 16,
  parameter int unsigned POS_MIN    = 0,
  parameter int unsigned POS_MAX    = 639,
  parameter int unsigned POS_INIT   = 320,
  parameter int unsigned TICK_DIV   = 833333,
  parameter int unsigned STEP_SHIFT = 0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [31:0]      rand_step,
  input  logic             load,
  input  logic [POS_W-1:0] load_pos,
  output logic [POS_W-1:0] pos,
  output logic             pos_valid,
  input  logic             pos_ready,
  output logic [15:0]      step_count,
  output logic             bounced,
  output logic             overrun
);

  localparam int unsigned ACC_W = POS_W + 2;
  localparam logic signed [ACC_W-1:0] MIN_S  = ACC_W'(POS_MIN);
  localparam logic signed [ACC_W-1:0] MAX_S  = ACC_W'(POS_MAX);
  localparam logic signed [ACC_W-1:0] MIN2_S = ACC_W'(2 * POS_MIN);
  localparam logic signed [ACC_W-1:0] MAX2_S = ACC_W'(2 * POS_MAX);
  localparam logic [POS_W-1:0] MIN_U  = POS_W'(POS_MIN);
  localparam logic [POS_W-1:0] MAX_U  = POS_W'(POS_MAX);
  localparam logic [POS_W-1:0] INIT_U = POS_W'(POS_INIT);

  rw_state_e               state;
  logic                    tick;
  logic signed [ACC_W-1:0] step_q;
  logic signed [ACC_W-1:0] nxt;
  logic signed [ACC_W-1:0] bounded;
  logic                    out_hi;
  logic                    out_lo;
  logic [POS_W-1:0]        load_clamped;
  logic                    unused_bits;

  assign unused_bits = ^{rand_step[31:STEP_W], bounded[ACC_W-1:POS_W]};

  rand_walk_tick #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clock   (clock),
    .reset_n (reset_n),
    .enable  (enable),
    .clear   (load),
    .tick    (tick)
  );

  always_comb begin
    nxt    = $signed({2'b00, pos}) + step_q;
    out_hi = nxt > MAX_S;
    out_lo = nxt < MIN_S;
`ifdef RAND_WALK_REFLECT_EN
    if (out_hi)      bounded = MAX2_S - nxt;
    else if (out_lo) bounded = MIN2_S - nxt;
    else             bounded = nxt;
    // A large step can reflect past the opposite bound; clamp the result.
    if (bounded > MAX_S)      bounded = MAX_S;
    else if (bounded < MIN_S) bounded = MIN_S;
`else
    if (out_hi)      bounded = MAX_S;
    else if (out_lo) bounded = MIN_S;
    else             bounded = nxt;
`endif
    if (load_pos > MAX_U)      load_clamped = MAX_U;
    else if (load_pos < MIN_U) load_clamped = MIN_U;
    else                       load_clamped = load_pos;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      pos        <= INIT_U;
      pos_valid  <= 1'b0;
      step_count <= '0;
      bounced    <= 1'b0;
      overrun    <= 1'b0;
      step_q     <= '0;
    end else if (load) begin
      state     <= ST_IDLE;
      pos       <= load_clamped;
      pos_valid <= 1'b0;
      bounced   <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (tick) state <= ST_SAMPLE;
        end
        ST_SAMPLE: begin
          step_q <= ACC_W'(step_scale(rand_step[STEP_W-1:0], STEP_SHIFT));
          state  <= ST_UPDATE;
        end
        ST_UPDATE: begin
          pos       <= bounded[POS_W-1:0];
          bounced   <= out_hi | out_lo;
          pos_valid <= 1'b1;
          state     <= ST_PUBLISH;
        end
        ST_PUBLISH: begin
          if (tick) overrun <= 1'b1;
          if (pos_ready) begin
            step_count <= step_count + 16'd1;
            pos_valid  <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
